// File: rtl/pe_mult_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : pe_mult_pipe_if
//  Purpose  : Handshake and data bundle for the lane-parallel PE multiplier.
//             master = producer/consumer side, slave = the multiplier pipe.
//             in_mode exists only when PE_MULT_INT8_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface pe_mult_pipe_if #(
  parameter int LANES = 32,
  parameter int DW    = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_signed;
`ifdef PE_MULT_INT8_EN
  logic                    in_mode;
`endif
  logic [LANES*DW-1:0]     mult_neuron;
  logic [LANES*DW-1:0]     mult_weight;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*2*DW-1:0]   mult_result;

`ifdef PE_MULT_INT8_EN
  modport master (
    output in_valid, in_signed, in_mode, mult_neuron, mult_weight, out_ready,
    input  in_ready, out_valid, mult_result
  );
  modport slave (
    input  in_valid, in_signed, in_mode, mult_neuron, mult_weight, out_ready,
    output in_ready, out_valid, mult_result
  );
`else
  modport master (
    output in_valid, in_signed, mult_neuron, mult_weight, out_ready,
    input  in_ready, out_valid, mult_result
  );
  modport slave (
    input  in_valid, in_signed, mult_neuron, mult_weight, out_ready,
    output in_ready, out_valid, mult_result
  );
`endif
endinterface
`default_nettype wire

// File: rtl/pe_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : pe_mult_pipe
//  Purpose  : Elastic STAGES-deep valid/ready pipeline of LANES independent
//             DW x DW multipliers producing full 2*DW-bit products.
//             Stage 0 holds operands; the multiply is its output logic;
//             later stages hold products.
//             Optional split (2 x DW/2) mode enabled by macro PE_MULT_INT8_EN.
//  Revision : 1.0  initial release
// ============================================================================
module pe_mult_pipe #(
  parameter int LANES  = 32,
  parameter int DW     = 16,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  pe_mult_pipe_if.slave     bus
);

  localparam int PW = 2 * DW;
  localparam int HW = DW / 2;

  logic [STAGES-1:0]     vld;
  logic [STAGES-1:0]     adv;
  logic                  accept;
  logic [LANES*DW-1:0]   s0_neu;
  logic [LANES*DW-1:0]   s0_wgt;
  logic                  s0_sgn;
`ifdef PE_MULT_INT8_EN
  logic                  s0_mode;
`endif
  logic [LANES*PW-1:0]   prod0;

  // Operand extension to product width; sign bit replicated only for signed beats
  function automatic logic [PW-1:0] sext_full(input logic [DW-1:0] v, input logic sg);
    return {{DW{sg & v[DW-1]}}, v};
  endfunction

`ifdef PE_MULT_INT8_EN
  function automatic logic [DW-1:0] sext_half(input logic [HW-1:0] v, input logic sg);
    return {{HW{sg & v[HW-1]}}, v};
  endfunction
`endif

  // Advance chain: walks back from the output so a drain at the tail frees every stage in one cycle
  always_comb begin : p_adv
    logic go;
    go  = bus.out_ready;
    adv = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = vld[k] & go;
      go     = ~vld[k] | adv[k];
    end
  end

  assign bus.in_ready  = ~vld[0] | adv[0];
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = vld[STAGES-1];

  // Valid bits: a stage fills when its upstream advances, empties when it advances alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else begin
      if (accept)      vld[0] <= 1'b1;
      else if (adv[0]) vld[0] <= 1'b0;
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k-1])    vld[k] <= 1'b1;
        else if (adv[k]) vld[k] <= 1'b0;
      end
    end
  end

  // Stage 0 operand capture together with the per-beat control bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_neu  <= '0;
      s0_wgt  <= '0;
      s0_sgn  <= 1'b0;
`ifdef PE_MULT_INT8_EN
      s0_mode <= 1'b0;
`endif
    end else if (accept) begin
      s0_neu  <= bus.mult_neuron;
      s0_wgt  <= bus.mult_weight;
      s0_sgn  <= bus.in_signed;
`ifdef PE_MULT_INT8_EN
      s0_mode <= bus.in_mode;
`endif
    end
  end

  // Per-lane multipliers; low 2*DW bits of the extended product are exact for both signednesses
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [PW-1:0] full_p;
    assign a      = s0_neu[i*DW +: DW];
    assign b      = s0_wgt[i*DW +: DW];
    assign full_p = sext_full(a, s0_sgn) * sext_full(b, s0_sgn);
`ifdef PE_MULT_INT8_EN
    logic [DW-1:0] lo_p;
    logic [DW-1:0] hi_p;
    assign lo_p = sext_half(a[HW-1:0], s0_sgn) * sext_half(b[HW-1:0], s0_sgn);
    assign hi_p = sext_half(a[DW-1:HW], s0_sgn) * sext_half(b[DW-1:HW], s0_sgn);
    assign prod0[i*PW +: PW] = s0_mode ? {hi_p, lo_p} : full_p;
`else
    assign prod0[i*PW +: PW] = full_p;
`endif
  end

  if (STAGES > 1) begin : g_tail
    logic [LANES*PW-1:0] data [1:STAGES-1];

    // Product stages: each loads from its upstream only when that stage advances
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 1; k < STAGES; k++) data[k] <= '0;
      end else begin
        if (adv[0]) data[1] <= prod0;
        for (int k = 2; k < STAGES; k++) begin
          if (adv[k-1]) data[k] <= data[k-1];
        end
      end
    end

    assign bus.mult_result = data[STAGES-1];
  end else begin : g_direct
    assign bus.mult_result = prod0;
  end

endmodule
`default_nettype wire

// File: doc/pe_mult_pipe.md
# pe_mult_pipe

Parametrised, pipelined lane-parallel multiplier for the DLP processing element. It takes packed neuron and weight vectors of `LANES` signed or unsigned `DW`-bit elements and returns the packed full-precision `2*DW`-bit products. An elastic valid/ready pipeline of `STAGES` registers accepts one vector per cycle and absorbs backpressure without loss. It sits between the PE input buffers and the PE accumulator/adder tree.

## Interface
- `LANES`, default 32: number of multiplier lanes; ≥1.
- `DW`, default 16: element width in bits; even, ≥4.
- `STAGES`, default 2: pipeline register stages; ≥1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  pipeline can accept a beat this cycle.
- `in_signed`  in  1  1 = signed operands, 0 = unsigned; captured with the beat.
- `in_mode`  in  1  present only with `PE_MULT_INT8_EN`; 1 = split-lane mode; captured with the beat.
- `mult_neuron`  in  `LANES*DW`  lane i at `[i*DW +: DW]`.
- `mult_weight`  in  `LANES*DW`  lane i at `[i*DW +: DW]`.
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  consumer accepts the result.
- `mult_result`  out  `LANES*2*DW`  lane i product at `[i*2*DW +: 2*DW]`.

## Operation
- A beat is accepted when `in_valid && in_ready`. A result is consumed when `out_valid && out_ready`.
- Full mode, and split mode with the macro absent: `product_i = a_i * b_i` at full `2*DW` width. With `in_signed=1`, operands are two's complement and the product is sign-correct. With `in_signed=0`, operands are zero-extended.
- No truncation, no shift, and no cross-lane interaction. Each lane writes only its own `2*DW` slot.
- The pipeline is a chain of `STAGES` registers. Each stage holds a valid bit, the operand or partial data, and the captured `in_signed`/`in_mode`.
- Stage k advances when it holds valid data and stage k+1 is empty or advancing. The last stage advances on `out_ready`.
- `in_ready = !valid[0] || advance[0]`. This is combinational from `out_ready` through the chain.
- The multiply is performed in stage 0's output logic. It may be split across stages, as long as latency and values match this spec.
- While `out_valid && !out_ready`: `mult_result` and `out_valid` hold stable.
- Stages behind a stall fill in place. No beat is dropped or duplicated.
- Reset, asynchronous:
  - all valid bits clear immediately, and `out_valid` drops to 0 without a clock;
  - data registers clear to 0, so `mult_result` reads 0;
  - `in_ready` reads 1 once reset is released.
- In-flight beats during reset are discarded.

## Timing
- Latency: a beat accepted at edge n appears with `out_valid=1` after edge n+`STAGES`, given no stall.
- Throughput: 1 beat per cycle with `out_ready` held high. Full-rate input never deasserts `in_ready`.
- Capacity: exactly `STAGES` beats in flight.
- Stall with a full pipeline: `in_ready=0` in the same cycle `out_ready=0`.
- Simultaneous accept and consume on a full pipeline is allowed. Occupancy is unchanged.
- `in_valid` may be asserted while `in_ready=0`. Inputs are ignored until a handshake occurs.

## Configuration
- Macro: `PE_MULT_INT8_EN`.
- Defined:
  - the `in_mode` port exists;
  - with `in_mode=1`, each `DW` lane is treated as two `DW/2` sub-elements (low = bits `[DW/2-1:0]`);
  - sub-products are `DW` bits wide, with the low sub-product at `[i*2*DW +: DW]` and the high sub-product at `[i*2*DW+DW +: DW]`;
  - `in_signed` applies to both halves;
  - `in_mode=0` gives the full-mode behaviour.
- Undefined: no `in_mode` port. Only full mode exists, and logic area excludes the split datapath.

## Test plan
- Smoke, `LANES=32`, `DW=16`, `STAGES=2`:
  - signed lane 0: `0x7FFF*0x7FFF` → `0x3FFF0001`;
  - signed lane 1: `0x8000*0x7FFF` → `0xC0008000`;
  - result appears exactly 2 cycles after accept.
- Unsigned: `0xFFFF*0xFFFF` with `in_signed=0` → `0xFFFE0001`. The same operands with `in_signed=1` → `0x00000001`.
- Backpressure: stream 10 beats with lane i = beat index at full rate, holding `out_ready=0` for cycles 3–6.
  - `in_ready` drops only when the pipeline is full;
  - all 10 results arrive in order and stay stable during the stall.
- Reset mid-flight: two beats in flight, then assert `rst` for 1 cycle.
  - `out_valid=0` and `mult_result=0` immediately;
  - no stale beat emerges afterwards;
  - `in_ready=1` after release.
- `PE_MULT_INT8_EN` with `in_mode=1`, signed:
  - neuron `0xFF03`, weight `0x0205` → lane 0 slot `0xFFFE_000F` (high `-1*2`, low `3*5`).
- Parameter sweep: `STAGES=1` and `4`, `LANES=1`, and `DW=8`. Random operands are checked against a reference model, with exact latency = `STAGES`.
